fetch_stage_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_stage_unit_if.sv | 29 ++
 rtl/if_id_register.sv | 44 ++++
 rtl/fetch_stage_unit.sv | 131 +++++++++++++
 tb/tb_fetch_stage_unit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and reset constants.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_unit_if.sv
// Hazard, redirect, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  PCWrite;
  logic                  IF_IDWrite;
  logic                  branchTaken;
  logic [ADDR_WIDTH-1:0] branchTarget;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic [31:0]           imem_rdata;
  logic [31:0]           IF_ID_instr;
  logic [ADDR_WIDTH-1:0] IF_ID_pc4;
  logic                  IF_ID_valid;
  logic                  fetchStall;
  logic [CNT_WIDTH-1:0]  stallCount;

  modport master (
    input  PCWrite, IF_IDWrite, branchTaken, branchTarget, imem_ready, imem_rdata,
    output imem_req, imem_addr, IF_ID_instr, IF_ID_pc4, IF_ID_valid, fetchStall, stallCount
  );

  modport slave (
    output PCWrite, IF_IDWrite, branchTaken, branchTarget, imem_ready, imem_rdata,
    input  imem_req, imem_addr, IF_ID_instr, IF_ID_pc4, IF_ID_valid, fetchStall, stallCount
  );
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats bubble beats a normal write; otherwise holds.
module if_id_register #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic                  i_flush,
  input  logic                  i_bubble,
  input  logic [31:0]           i_instr,
  input  logic [ADDR_WIDTH-1:0] i_pc4,
  output logic [31:0]           o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc4,
  output logic                  o_valid
);
  logic [31:0]           r_instr;
  logic [ADDR_WIDTH-1:0] r_pc4;
  logic                  r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_bubble) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= i_pc4;
      r_valid <= 1'b0;
    end else if (i_we) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;
endmodule

// File: rtl/fetch_stage_unit.sv
// Instruction-fetch stage: PC, imem handshake FSM, stall counter and IF/ID register.
module fetch_stage_unit #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(cpu_pkg::RESET_PC),
  parameter int unsigned            CNT_WIDTH  = 16,
  parameter logic [31:0]            NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input logic                clk,
  input logic                rst_n,
  fetch_stage_unit_if.master bus
);
  import cpu_pkg::*;

  fetch_state_e          r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt, w_pc4;
  logic [ADDR_WIDTH-1:0] r_redirect, w_redirect_nxt;
  logic [31:0]           r_hold_buf, w_hold_buf_nxt;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic                  w_hz_stall, w_fetch_stall, w_we, w_flush, w_bubble, w_req;
  logic [31:0]           w_ifid_instr;

  assign w_hz_stall = !(bus.PCWrite & bus.IF_IDWrite);
  assign w_pc4      = r_pc + ADDR_WIDTH'(4);

  // Next state, PC/redirect/buffer updates and IF/ID control; branch outranks everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_redirect_nxt = r_redirect;
    w_hold_buf_nxt = r_hold_buf;
    w_we           = 1'b0;
    w_flush        = 1'b0;
    w_bubble       = 1'b0;
    w_fetch_stall  = 1'b0;
    w_req          = 1'b1;
    w_ifid_instr   = bus.imem_rdata;
    case (r_state)
      FETCH: begin
        if (bus.branchTaken) begin
          w_flush = 1'b1;
          if (bus.imem_ready) begin
            w_pc_nxt = bus.branchTarget;
          end else begin
            w_redirect_nxt = bus.branchTarget;
            w_state_nxt    = DISCARD;
          end
        end else if (bus.imem_ready) begin
          if (!w_hz_stall) begin
            w_we     = 1'b1;
            w_pc_nxt = w_pc4;
          end else begin
            w_hold_buf_nxt = bus.imem_rdata;
            w_state_nxt    = HOLD;
          end
        end else begin
          w_fetch_stall = 1'b1;
          w_bubble      = !w_hz_stall;
        end
      end
      HOLD: begin
        w_req = 1'b0;
        if (bus.branchTaken) begin
          w_flush     = 1'b1;
          w_pc_nxt    = bus.branchTarget;
          w_state_nxt = FETCH;
        end else if (!w_hz_stall) begin
          w_we         = 1'b1;
          w_ifid_instr = r_hold_buf;
          w_pc_nxt     = w_pc4;
          w_state_nxt  = FETCH;
        end
      end
      DISCARD: begin
        // Old request stays on the bus until it completes; its data is dropped.
        w_flush = bus.branchTaken;
        if (bus.imem_ready) begin
          w_pc_nxt    = bus.branchTaken ? bus.branchTarget : r_redirect;
          w_state_nxt = FETCH;
        end else if (bus.branchTaken) begin
          w_redirect_nxt = bus.branchTarget;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_redirect <= '0;
      r_hold_buf <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_redirect <= w_redirect_nxt;
      r_hold_buf <= w_hold_buf_nxt;
    end
  end

  // Saturating count of cycles lost to hazards, memory waits or discards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((w_hz_stall | w_fetch_stall | (r_state == DISCARD)) & !bus.branchTaken
                 & (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  if_id_register #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_we),
    .i_flush  (w_flush),
    .i_bubble (w_bubble),
    .i_instr  (w_ifid_instr),
    .i_pc4    (w_pc4),
    .o_instr  (bus.IF_ID_instr),
    .o_pc4    (bus.IF_ID_pc4),
    .o_valid  (bus.IF_ID_valid)
  );

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_pc;
  assign bus.fetchStall = w_fetch_stall;
  assign bus.stallCount = r_stall_cnt;
endmodule

// File: tb/tb_fetch_stage_unit.sv
// Directed vector bench for fetch_stage_unit: per-cycle inputs with expected bus and IF/ID values.
module tb_fetch_stage_unit;

  typedef struct {
    logic        pcw;
    logic        ifw;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic        e_req;
    logic        e_fstall;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  vec_t vecs[$];

  fetch_stage_unit_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bus ();

  fetch_stage_unit #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .CNT_WIDTH  (16),
    .NOP_INSTR  (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic pcw, input logic ifw, input logic br,
                              input logic [31:0] tgt, input logic rdy, input logic [31:0] rdata,
                              input logic [31:0] e_addr, input logic e_req, input logic e_fstall,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic e_valid, input logic [15:0] e_cnt);
    vec_t v;
    v.pcw = pcw; v.ifw = ifw; v.br = br; v.tgt = tgt; v.rdy = rdy; v.rdata = rdata;
    v.e_addr = e_addr; v.e_req = e_req; v.e_fstall = e_fstall;
    v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input logic pcw, input logic ifw, input logic br,
                       input logic [31:0] tgt, input logic rdy, input logic [31:0] rdata);
    bus.PCWrite      = pcw;
    bus.IF_IDWrite   = ifw;
    bus.branchTaken  = br;
    bus.branchTarget = tgt;
    bus.imem_ready   = rdy;
    bus.imem_rdata   = rdata;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_instr"}, bus.IF_ID_instr, 32'h0);
    chk({tag, "_pc4"},   bus.IF_ID_pc4,   32'h0);
    chk({tag, "_valid"}, 32'(bus.IF_ID_valid), 32'h0);
    chk({tag, "_cnt"},   32'(bus.stallCount), 32'h0);
    chk({tag, "_addr"},  bus.imem_addr,   32'h0);
    chk({tag, "_req"},   32'(bus.imem_req), 32'h1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    //       pcw ifw br  tgt           rdy rdata         addr          req fst instr         pc4           v  cnt
    // zero-wait fetch
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h20080005, 32'h0000_0000, 1, 0, 32'h20080005, 32'h0000_0004, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h20090003, 32'h0000_0004, 1, 0, 32'h20090003, 32'h0000_0008, 1, 0));
    // load-use stall -> HOLD, then buffered word released
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h012A4020, 32'h0000_0008, 1, 0, 32'h20090003, 32'h0000_0008, 1, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'hFFFFFFFF, 32'h0000_0008, 0, 0, 32'h012A4020, 32'h0000_000C, 1, 1));
    // three memory wait cycles insert bubbles
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'hFFFFFFFF, 32'h0000_000C, 1, 1, 32'h0,        32'h0000_0010, 0, 2));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'hFFFFFFFF, 32'h0000_000C, 1, 1, 32'h0,        32'h0000_0010, 0, 3));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'hFFFFFFFF, 32'h0000_000C, 1, 1, 32'h0,        32'h0000_0010, 0, 4));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h8D0B0004, 32'h0000_000C, 1, 0, 32'h8D0B0004, 32'h0000_0010, 1, 4));
    // branch while hazard (PCWrite/IF_IDWrite mismatch)
    vecs.push_back(mk(0, 1, 1, 32'h40,       1, 32'hDEADBEEF, 32'h0000_0010, 1, 0, 32'h0,        32'h0,         0, 4));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h11111111, 32'h0000_0040, 1, 0, 32'h11111111, 32'h0000_0044, 1, 4));
    // branch with outstanding request -> DISCARD
    vecs.push_back(mk(1, 1, 1, 32'h80,       0, 32'hFFFFFFFF, 32'h0000_0044, 1, 0, 32'h0,        32'h0,         0, 4));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'hFFFFFFFF, 32'h0000_0044, 1, 0, 32'h0,        32'h0,         0, 5));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'hBADBAD00, 32'h0000_0044, 1, 0, 32'h0,        32'h0,         0, 6));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h22222222, 32'h0000_0080, 1, 0, 32'h22222222, 32'h0000_0084, 1, 6));
    // second branch in DISCARD overwrites the latched target
    vecs.push_back(mk(1, 1, 1, 32'h100,      0, 32'hFFFFFFFF, 32'h0000_0084, 1, 0, 32'h0,        32'h0,         0, 6));
    vecs.push_back(mk(1, 1, 1, 32'h200,      0, 32'hFFFFFFFF, 32'h0000_0084, 1, 0, 32'h0,        32'h0,         0, 6));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'hFFFFFFFF, 32'h0000_0084, 1, 0, 32'h0,        32'h0,         0, 7));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h33333333, 32'h0000_0200, 1, 0, 32'h33333333, 32'h0000_0204, 1, 7));
    // hazard into HOLD, stay, then branch out of HOLD to the top of memory
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h44444444, 32'h0000_0204, 1, 0, 32'h33333333, 32'h0000_0204, 1, 8));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hFFFFFFFF, 32'h0000_0204, 0, 0, 32'h33333333, 32'h0000_0204, 1, 9));
    vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFF, 32'h0000_0204, 0, 0, 32'h0,        32'h0,         0, 9));
    // PC wraps past 0xFFFFFFFC
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h55555555, 32'hFFFF_FFFC, 1, 0, 32'h55555555, 32'h0000_0000, 1, 9));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h66666666, 32'h0000_0000, 1, 0, 32'h66666666, 32'h0000_0004, 1, 9));

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].pcw, vecs[i].ifw, vecs[i].br, vecs[i].tgt, vecs[i].rdy, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_addr", i),   bus.imem_addr,         vecs[i].e_addr);
      chk($sformatf("v%0d_req", i),    32'(bus.imem_req),     32'(vecs[i].e_req));
      chk($sformatf("v%0d_fstall", i), 32'(bus.fetchStall),   32'(vecs[i].e_fstall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_instr", i),  bus.IF_ID_instr,       vecs[i].e_instr);
      chk($sformatf("v%0d_pc4", i),    bus.IF_ID_pc4,         vecs[i].e_pc4);
      chk($sformatf("v%0d_valid", i),  32'(bus.IF_ID_valid),  32'(vecs[i].e_valid));
      chk($sformatf("v%0d_cnt", i),    32'(bus.stallCount),   32'(vecs[i].e_cnt));
    end

    // Enter HOLD at PC=0x8, then pull reset between clock edges.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h77777777);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h88888888);
    @(posedge clk); #1;
    chk("hold_req", 32'(bus.imem_req), 32'h0);
    chk("hold_addr", bus.imem_addr, 32'h0000_0008);
    chk("hold_cnt", 32'(bus.stallCount), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    #1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h99999999);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_instr", bus.IF_ID_instr, 32'h99999999);
    chk("post_rst_pc4", bus.IF_ID_pc4, 32'h0000_0004);
    chk("post_rst_addr", bus.imem_addr, 32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
